id_stage: RTL and testbench

Instruction-decode stage of the 5-stage RV32 pipeline; the consumer of the IF/ID register. Holds the 32×32 integer register file, decodes the R/I/load/store/beq subset, resolves `beq` in ID, and detects load-use and branch-operand hazards. Drives stall, flush and redirect controls back to fetch, and registers decoded operands and controls into the ID/EX pipeline register.

---
 rtl/id_stage.sv | 196 +++++++++++++++++++
 tb/tb_id_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32 decode stage with register file, R/I/load/store/beq decode, in-ID beq resolve and hazard stalls.
// Define ID_BRANCH_FWD_EN to feed EX/MEM ALU results into the beq comparator instead of stalling.
module id_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IF_ID_pc,
    input  logic [31:0] IF_ID_inst,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        EX_MEM_reg_write,
    input  logic        EX_MEM_mem_read,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [31:0] EX_MEM_alu_result,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        IF_flush,
    output logic        pc_control,
    output logic [31:0] pc_branch,
    output logic [31:0] ID_EX_pc,
    output logic [31:0] ID_EX_rs1_data,
    output logic [31:0] ID_EX_rs2_data,
    output logic [31:0] ID_EX_imm,
    output logic [4:0]  ID_EX_rs1,
    output logic [4:0]  ID_EX_rs2,
    output logic [4:0]  ID_EX_rd,
    output logic [2:0]  ID_EX_funct3,
    output logic        ID_EX_funct7b5,
    output logic        ID_EX_reg_write,
    output logic        ID_EX_mem_read,
    output logic        ID_EX_mem_write,
    output logic        ID_EX_mem_to_reg,
    output logic        ID_EX_alu_src,
    output logic [1:0]  ID_EX_alu_op
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic [1:0]  alu_op;
    } id_ex_t;

    function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    id_ex_t      id_ex_p1_q, id_ex_p1_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        is_r, is_i, is_ld, is_st, is_beq, use_rs1, use_rs2;
    logic [31:0] rs1_val, rs2_val, br_a, br_b;
    logic signed [31:0] imm_sel, imm_br;
    logic        ex_m1, ex_m2, mem_m1, mem_m2, em_stall;
    logic        load_use, br_stall, stall, taken;

    assign opcode  = IF_ID_inst[6:0];
    assign rd      = IF_ID_inst[11:7];
    assign funct3  = IF_ID_inst[14:12];
    assign rs1     = IF_ID_inst[19:15];
    assign rs2     = IF_ID_inst[24:20];
    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_beq  = (opcode == OP_BR) && (funct3 == 3'b000);
    assign use_rs1 = is_r | is_i | is_ld | is_st | is_beq;
    assign use_rs2 = is_r | is_st | is_beq;
    assign imm_br  = imm_b(IF_ID_inst);

    always_comb begin
        imm_sel = '0;
        if (is_i || is_ld) imm_sel = imm_i(IF_ID_inst);
        else if (is_st)    imm_sel = imm_s(IF_ID_inst);
        else if (is_beq)   imm_sel = imm_br;
    end

    // Write-through lets a WB write in this cycle reach the decode without a bypass stage.
    always_comb begin
        rs1_val = rf_q[rs1];
        rs2_val = rf_q[rs2];
        if (wb_reg_write && (wb_rd == rs1)) rs1_val = wb_data;
        if (wb_reg_write && (wb_rd == rs2)) rs2_val = wb_data;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_reg_write && (wb_rd != 5'd0)) rf_d[wb_rd] = wb_data;
    end

    assign ex_m1    = use_rs1 && (id_ex_p1_q.rd != 5'd0) && (id_ex_p1_q.rd == rs1);
    assign ex_m2    = use_rs2 && (id_ex_p1_q.rd != 5'd0) && (id_ex_p1_q.rd == rs2);
    assign mem_m1   = (EX_MEM_rd != 5'd0) && (EX_MEM_rd == rs1);
    assign mem_m2   = (EX_MEM_rd != 5'd0) && (EX_MEM_rd == rs2);
    assign load_use = id_ex_p1_q.mem_read && (ex_m1 || ex_m2);

`ifdef ID_BRANCH_FWD_EN
    // A load result is not ready in EX/MEM yet, so only ALU producers forward.
    assign em_stall = EX_MEM_mem_read && (mem_m1 || mem_m2);
    assign br_a = (EX_MEM_reg_write && !EX_MEM_mem_read && mem_m1) ? EX_MEM_alu_result : rs1_val;
    assign br_b = (EX_MEM_reg_write && !EX_MEM_mem_read && mem_m2) ? EX_MEM_alu_result : rs2_val;
`else
    logic unused_alu_result;
    assign unused_alu_result = ^EX_MEM_alu_result;
    assign em_stall = (EX_MEM_reg_write || EX_MEM_mem_read) && (mem_m1 || mem_m2);
    assign br_a = rs1_val;
    assign br_b = rs2_val;
`endif

    assign br_stall    = is_beq && ((id_ex_p1_q.reg_write && (ex_m1 || ex_m2)) || em_stall);
    assign stall       = load_use || br_stall;
    assign taken       = is_beq && !stall && (br_a == br_b);
    assign pc_write    = !stall;
    assign IF_ID_write = !stall;
    assign IF_flush    = taken;
    assign pc_control  = taken;
    assign pc_branch   = IF_ID_pc + $unsigned(imm_br);

    // ---- ID -> EX boundary: data always advances, controls are squashed on stall ----
    always_comb begin
        id_ex_p1_d          = '0;
        id_ex_p1_d.pc       = IF_ID_pc;
        id_ex_p1_d.rs1_data = rs1_val;
        id_ex_p1_d.rs2_data = rs2_val;
        id_ex_p1_d.imm      = $unsigned(imm_sel);
        id_ex_p1_d.rs1      = rs1;
        id_ex_p1_d.rs2      = rs2;
        id_ex_p1_d.rd       = rd;
        id_ex_p1_d.funct3   = funct3;
        id_ex_p1_d.funct7b5 = IF_ID_inst[30];
        if (!stall) begin
            id_ex_p1_d.reg_write  = is_r | is_i | is_ld;
            id_ex_p1_d.mem_read   = is_ld;
            id_ex_p1_d.mem_write  = is_st;
            id_ex_p1_d.mem_to_reg = is_ld;
            id_ex_p1_d.alu_src    = is_i | is_ld | is_st;
            id_ex_p1_d.alu_op     = (is_r || is_i) ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_q       <= '{default: '0};
            id_ex_p1_q <= '0;
        end else begin
            rf_q       <= rf_d;
            id_ex_p1_q <= id_ex_p1_d;
        end
    end

    assign ID_EX_pc         = id_ex_p1_q.pc;
    assign ID_EX_rs1_data   = id_ex_p1_q.rs1_data;
    assign ID_EX_rs2_data   = id_ex_p1_q.rs2_data;
    assign ID_EX_imm        = id_ex_p1_q.imm;
    assign ID_EX_rs1        = id_ex_p1_q.rs1;
    assign ID_EX_rs2        = id_ex_p1_q.rs2;
    assign ID_EX_rd         = id_ex_p1_q.rd;
    assign ID_EX_funct3     = id_ex_p1_q.funct3;
    assign ID_EX_funct7b5   = id_ex_p1_q.funct7b5;
    assign ID_EX_reg_write  = id_ex_p1_q.reg_write;
    assign ID_EX_mem_read   = id_ex_p1_q.mem_read;
    assign ID_EX_mem_write  = id_ex_p1_q.mem_write;
    assign ID_EX_mem_to_reg = id_ex_p1_q.mem_to_reg;
    assign ID_EX_alu_src    = id_ex_p1_q.alu_src;
    assign ID_EX_alu_op     = id_ex_p1_q.alu_op;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: fetch controls checked in-cycle, ID/EX contents checked one cycle later.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] IF_ID_pc, IF_ID_inst;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        EX_MEM_reg_write, EX_MEM_mem_read;
    logic [4:0]  EX_MEM_rd;
    logic [31:0] EX_MEM_alu_result;
    logic        pc_write, IF_ID_write, IF_flush, pc_control;
    logic [31:0] pc_branch, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [2:0]  ID_EX_funct3;
    logic        ID_EX_funct7b5, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write;
    logic        ID_EX_mem_to_reg, ID_EX_alu_src;
    logic [1:0]  ID_EX_alu_op;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset_n(reset_n), .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .EX_MEM_reg_write(EX_MEM_reg_write), .EX_MEM_mem_read(EX_MEM_mem_read),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_alu_result(EX_MEM_alu_result),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_flush(IF_flush),
        .pc_control(pc_control), .pc_branch(pc_branch), .ID_EX_pc(ID_EX_pc),
        .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_funct3(ID_EX_funct3), .ID_EX_funct7b5(ID_EX_funct7b5),
        .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
        .ID_EX_mem_write(ID_EX_mem_write), .ID_EX_mem_to_reg(ID_EX_mem_to_reg),
        .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_alu_op(ID_EX_alu_op)
    );

    // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op}
    localparam logic [6:0] C_R = 7'b1000010, C_I = 7'b1000110, C_LD = 7'b1101100;
    localparam logic [6:0] C_ST = 7'b0010100, C_BEQ = 7'b0000001, C_NONE = 7'b0000000;
    // fetch = {pc_write, IF_ID_write, IF_flush, pc_control}
    localparam logic [3:0] F_RUN = 4'b1100, F_STALL = 4'b0000, F_TAKE = 4'b1111;

    localparam logic [31:0] I_SUB   = 32'h40308133; // sub  x2,x1,x3
    localparam logic [31:0] I_ADDIM = 32'hFFF58393; // addi x7,x11,-1
    localparam logic [31:0] I_LW7   = 32'h0142A383; // lw   x7,20(x5)
    localparam logic [31:0] I_SW7   = 32'h0072A623; // sw   x7,12(x5)
    localparam logic [31:0] I_BEQA  = 32'h00A08C63; // beq  x1,x10,+24
    localparam logic [31:0] I_BEQN  = 32'hFEA08CE3; // beq  x1,x10,-8
    localparam logic [31:0] I_LW14  = 32'h00012703; // lw   x14,0(x2)
    localparam logic [31:0] I_BEQE  = 32'h00E08C63; // beq  x1,x14,+24
    localparam logic [31:0] I_ADD0  = 32'h000001B3; // add  x3,x0,x0

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic        chk_imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [6:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, rs1d, rs2d, imm, input logic chk_imm,
                                input logic [4:0] rs1, rs2, rd, input logic [2:0] f3,
                                input logic f7, input logic [6:0] ctrl);
        exp_t e;
        e = '{pc: pc, rs1d: rs1d, rs2d: rs2d, imm: imm, chk_imm: chk_imm, rs1: rs1, rs2: rs2,
              rd: rd, f3: f3, f7: f7, ctrl: ctrl};
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("idex.pc", ID_EX_pc, e.pc);
            check_eq("idex.rs1_data", ID_EX_rs1_data, e.rs1d);
            check_eq("idex.rs2_data", ID_EX_rs2_data, e.rs2d);
            if (e.chk_imm) check_eq("idex.imm", ID_EX_imm, e.imm);
            check_eq("idex.rs1", 32'(ID_EX_rs1), 32'(e.rs1));
            check_eq("idex.rs2", 32'(ID_EX_rs2), 32'(e.rs2));
            check_eq("idex.rd", 32'(ID_EX_rd), 32'(e.rd));
            check_eq("idex.funct", 32'({ID_EX_funct3, ID_EX_funct7b5}), 32'({e.f3, e.f7}));
            check_eq("idex.ctrl", 32'({ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write,
                     ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_alu_op}), 32'(e.ctrl));
        end
    end

    task automatic step(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [3:0] fe, input logic chk_br, input logic [31:0] br,
                        input logic push, input exp_t e);
        @(negedge clk);
        IF_ID_inst = inst;
        IF_ID_pc   = pc;
        #1;
        check_eq({tag, ".fetch"}, 32'({pc_write, IF_ID_write, IF_flush, pc_control}), 32'(fe));
        if (chk_br) check_eq({tag, ".pc_branch"}, pc_branch, br);
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        EX_MEM_reg_write = 1'b0; EX_MEM_mem_read = 1'b0; EX_MEM_rd = '0; EX_MEM_alu_result = '0;
    endtask

    task automatic setreg(input logic [4:0] r, input logic [31:0] d);
        wb_reg_write = 1'b1; wb_rd = r; wb_data = d;
        step("setreg", 32'h0, 32'h0, F_RUN, 1'b0, 32'h0, 1'b0, '0);
    endtask

    task automatic check_idex_zero(input string tag);
        check_eq({tag, ".pc"}, ID_EX_pc, 32'h0);
        check_eq({tag, ".rs1_data"}, ID_EX_rs1_data, 32'h0);
        check_eq({tag, ".imm"}, ID_EX_imm, 32'h0);
        check_eq({tag, ".regs"}, 32'({ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_funct3, ID_EX_funct7b5}), 32'h0);
        check_eq({tag, ".ctrl"}, 32'({ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write,
                 ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_alu_op}), 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; IF_ID_pc = '0; IF_ID_inst = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        EX_MEM_reg_write = 1'b0; EX_MEM_mem_read = 1'b0; EX_MEM_rd = '0; EX_MEM_alu_result = '0;
        #1;
        check_idex_zero("reset");
        check_eq("reset.fetch", 32'({pc_write, IF_ID_write, IF_flush, pc_control}), 32'(F_RUN));
        check_eq("reset.pc_branch", pc_branch, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        setreg(5'd1, 32'd10); setreg(5'd3, 32'd3); setreg(5'd5, 32'h100);
        setreg(5'd7, 32'h77); setreg(5'd11, 32'h11); setreg(5'd10, 32'd5);

        step("sub", I_SUB, 32'h40, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h40, 32'd10, 32'd3, 32'h0, 1'b0, 5'd1, 5'd3, 5'd2, 3'd0, 1'b1, C_R));
        step("addi_neg", I_ADDIM, 32'h44, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h44, 32'h11, 32'h0, 32'hFFFFFFFF, 1'b1, 5'd11, 5'd31, 5'd7, 3'd0, 1'b1, C_I));

        step("lw7", I_LW7, 32'h48, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h48, 32'h100, 32'h0, 32'd20, 1'b1, 5'd5, 5'd20, 5'd7, 3'd2, 1'b0, C_LD));
        step("sw_stall", I_SW7, 32'h4C, F_STALL, 1'b0, 32'h0, 1'b1,
             mk(32'h4C, 32'h100, 32'h77, 32'd12, 1'b1, 5'd5, 5'd7, 5'd12, 3'd2, 1'b0, C_NONE));
        step("sw_go", I_SW7, 32'h4C, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h4C, 32'h100, 32'h77, 32'd12, 1'b1, 5'd5, 5'd7, 5'd12, 3'd2, 1'b0, C_ST));

        setreg(5'd1, 32'd5);
        step("beq_taken", I_BEQA, 32'h1C, F_TAKE, 1'b1, 32'h34, 1'b1,
             mk(32'h1C, 32'd5, 32'd5, 32'd24, 1'b1, 5'd1, 5'd10, 5'd24, 3'd0, 1'b0, C_BEQ));
        step("beq_back", I_BEQN, 32'h1C, F_TAKE, 1'b1, 32'h14, 1'b1,
             mk(32'h1C, 32'd5, 32'd5, 32'hFFFFFFF8, 1'b1, 5'd1, 5'd10, 5'd25, 3'd0, 1'b1, C_BEQ));
        setreg(5'd10, 32'd6);
        step("beq_not", I_BEQA, 32'h1C, F_RUN, 1'b1, 32'h34, 1'b1,
             mk(32'h1C, 32'd5, 32'd6, 32'd24, 1'b1, 5'd1, 5'd10, 5'd24, 3'd0, 1'b0, C_BEQ));

        setreg(5'd14, 32'h99);
        step("lw14", I_LW14, 32'h60, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h60, 32'h0, 32'h0, 32'h0, 1'b1, 5'd2, 5'd0, 5'd14, 3'd2, 1'b0, C_LD));
        step("beqlw_s1", I_BEQE, 32'h64, F_STALL, 1'b1, 32'h7C, 1'b1,
             mk(32'h64, 32'd5, 32'h99, 32'd24, 1'b1, 5'd1, 5'd14, 5'd24, 3'd0, 1'b0, C_NONE));
        EX_MEM_reg_write = 1'b1; EX_MEM_mem_read = 1'b1; EX_MEM_rd = 5'd14;
        step("beqlw_s2", I_BEQE, 32'h64, F_STALL, 1'b1, 32'h7C, 1'b1,
             mk(32'h64, 32'd5, 32'h99, 32'd24, 1'b1, 5'd1, 5'd14, 5'd24, 3'd0, 1'b0, C_NONE));
        wb_reg_write = 1'b1; wb_rd = 5'd14; wb_data = 32'd5;
        step("beqlw_go", I_BEQE, 32'h64, F_TAKE, 1'b1, 32'h7C, 1'b1,
             mk(32'h64, 32'd5, 32'd5, 32'd24, 1'b1, 5'd1, 5'd14, 5'd24, 3'd0, 1'b0, C_BEQ));

        setreg(5'd14, 32'h77);
        EX_MEM_reg_write = 1'b1; EX_MEM_rd = 5'd14; EX_MEM_alu_result = 32'd5;
`ifdef ID_BRANCH_FWD_EN
        step("beqfwd", I_BEQE, 32'h64, F_TAKE, 1'b1, 32'h7C, 1'b1,
             mk(32'h64, 32'd5, 32'h77, 32'd24, 1'b1, 5'd1, 5'd14, 5'd24, 3'd0, 1'b0, C_BEQ));
`else
        step("beqalu_s", I_BEQE, 32'h64, F_STALL, 1'b1, 32'h7C, 1'b1,
             mk(32'h64, 32'd5, 32'h77, 32'd24, 1'b1, 5'd1, 5'd14, 5'd24, 3'd0, 1'b0, C_NONE));
        wb_reg_write = 1'b1; wb_rd = 5'd14; wb_data = 32'd5;
        step("beqalu_go", I_BEQE, 32'h64, F_TAKE, 1'b1, 32'h7C, 1'b1,
             mk(32'h64, 32'd5, 32'd5, 32'd24, 1'b1, 5'd1, 5'd14, 5'd24, 3'd0, 1'b0, C_BEQ));
`endif

        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        step("x0_wt", I_ADD0, 32'h80, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h80, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 3'd0, 1'b0, C_R));
        step("x0_rd", I_ADD0, 32'h84, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h84, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 3'd0, 1'b0, C_R));

        // Reset asserted in the middle of a load-use stall cycle.
        step("lw7b", I_LW7, 32'h48, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h48, 32'h100, 32'h0, 32'd20, 1'b1, 5'd5, 5'd20, 5'd7, 3'd2, 1'b0, C_LD));
        @(negedge clk);
        IF_ID_inst = I_SW7; IF_ID_pc = 32'h4C;
        #1;
        check_eq("rst_stall.fetch", 32'({pc_write, IF_ID_write, IF_flush, pc_control}), 32'(F_STALL));
        #2 reset_n = 1'b0;
        #1;
        check_idex_zero("rst_async");
        IF_ID_inst = '0; IF_ID_pc = '0;
        #1;
        check_eq("rst_async.fetch", 32'({pc_write, IF_ID_write, IF_flush, pc_control}), 32'(F_RUN));
        check_eq("rst_async.pc_branch", pc_branch, 32'h0);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step("rf_cleared", I_SUB, 32'h90, F_RUN, 1'b0, 32'h0, 1'b1,
             mk(32'h90, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1, 5'd3, 5'd2, 3'd0, 1'b1, C_R));

        repeat (2) @(posedge clk);
        check_eq("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
